// File: rtl/hold_seq_pkg.sv
// Shared types and helpers for the hold_seq burst sequencer.
// State encodings, display names and the pointer-width helper.
package hold_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    function automatic string state_name(input state_t s);
        case (s)
            IDLE:    return "IDLE";
            RUN:     return "RUN";
            LAST:    return "LAST";
            default: return "ILLEGAL";
        endcase
    endfunction

    // A single channel still needs a 1-bit pointer port.
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_seq_tog_bank.sv
// Rotating pointer plus per-channel toggle flops; one flip per adv pulse.
// Updates on the edge adv is sampled; no backpressure.
module hold_seq_tog_bank
    import hold_seq_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    output logic [N_CH-1:0]          tog,
    output logic [ptr_w(N_CH)-1:0]   ch_ptr
);

    localparam int              PW      = ptr_w(N_CH);
    localparam logic [PW-1:0]   LAST_CH = PW'(N_CH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog    <= '0;
            ch_ptr <= '0;
        end else if (adv) begin
            tog    <= tog ^ (N_CH'(1) << ch_ptr);
            ch_ptr <= (ch_ptr == LAST_CH) ? '0 : ch_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/hold_seq.sv
// Burst/pacing sequencer: IDLE -> RUN (L+1 cycles) -> LAST (1 cycle), held busy window.
// All outputs registered; abort cancels a burst from IDLE or RUN without done or toggle.
module hold_seq
    import hold_seq_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int N_CH       = 2,
    parameter bit AUTO_START = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         run_len,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH-1:0]          tog,
    output logic [ptr_w(N_CH)-1:0]   ch_ptr,
    output logic [CNT_W-1:0]         cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   len_q;
    logic               go;
    logic               adv;
    logic [CNT_W-1:0]   cnt_inc;

    assign go      = (start | AUTO_START) & ~abort;
    assign adv     = (state == LAST);
    // Saturate so a maximal run length still reads all-ones during LAST.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = RUN;
            RUN: begin
                if (abort)              state_nxt = IDLE;
                else if (cnt >= len_q)  state_nxt = LAST;
            end
            LAST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN) || (state_nxt == LAST);
            done  <= (state == LAST);
            cnt   <= (state == RUN && state_nxt != IDLE) ? cnt_inc : '0;
            if (state == IDLE && go) len_q <= run_len;
        end
    end

    hold_seq_tog_bank #(
        .N_CH (N_CH)
    ) u_tog_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (adv),
        .tog    (tog),
        .ch_ptr (ch_ptr)
    );

endmodule

// File: tb/tb_hold_seq.sv
// Directed + random bench for hold_seq: a start-triggered instance and a free-running one,
// both compared each cycle against a burst-position reference model.
module tb_hold_seq;
    import hold_seq_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start0 = 0, abort0 = 0, start1 = 0, abort1 = 0;
    logic [CW-1:0]   len0 = 0, len1 = 2;
    logic            busy0, done0, busy1, done1;
    logic [1:0]      tog0;
    logic [2:0]      tog1;
    logic [ptr_w(2)-1:0] ptr0;
    logic [ptr_w(3)-1:0] ptr1;
    logic [CW-1:0]   cnt0, cnt1;

    hold_seq #(.CNT_W(CW), .N_CH(2), .AUTO_START(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .run_len(len0),
        .busy(busy0), .done(done0), .tog(tog0), .ch_ptr(ptr0), .cnt(cnt0));

    hold_seq #(.CNT_W(CW), .N_CH(3), .AUTO_START(1'b1)) dut_auto (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .run_len(len1),
        .busy(busy1), .done(done1), .tog(tog1), .ch_ptr(ptr1), .cnt(cnt1));

    int errors = 0;
    int checks = 0;

    // Model: a burst is a position k = 0..L+1 counted from the accepting edge.
    bit m_in[2];
    int m_k[2];
    int m_len[2];
    bit m_done[2];
    int m_tog[2];
    int m_ptr[2];
    int nch[2]   = '{2, 3};
    bit autos[2] = '{1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_in[i] = 0; m_k[i] = 0; m_len[i] = 0;
            m_done[i] = 0; m_tog[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit st, input bit ab, input int rl);
        m_done[i] = m_in[i] && (m_k[i] == m_len[i] + 1);
        if (!m_in[i]) begin
            if ((st || autos[i]) && !ab) begin
                m_in[i] = 1; m_k[i] = 0; m_len[i] = rl;
            end
        end else if (m_k[i] == m_len[i] + 1) begin
            m_in[i]  = 0;
            m_tog[i] = m_tog[i] ^ (1 << m_ptr[i]);
            m_ptr[i] = (m_ptr[i] + 1) % nch[i];
        end else if (ab) begin
            m_in[i] = 0;
        end else begin
            m_k[i]++;
        end
    endtask

    function automatic int exp_cnt(input int i);
        if (!m_in[i]) return 0;
        return (m_k[i] > CMAX) ? CMAX : m_k[i];
    endfunction

    task automatic check_all();
        chk("s0 busy", busy0, m_in[0]);
        chk("s0 done", done0, m_done[0]);
        chk("s0 cnt",  cnt0,  exp_cnt(0));
        chk("s0 tog",  tog0,  m_tog[0]);
        chk("s0 ptr",  ptr0,  m_ptr[0]);
        chk("a1 busy", busy1, m_in[1]);
        chk("a1 done", done1, m_done[1]);
        chk("a1 cnt",  cnt1,  exp_cnt(1));
        chk("a1 tog",  tog1,  m_tog[1]);
        chk("a1 ptr",  ptr1,  m_ptr[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, start0, abort0, int'(len0));
        model_step(1, start1, abort1, int'(len1));
        #1;
        check_all();
    endtask

    initial begin
        int busy_cycles;
        int waited;

        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Single burst, L=5: busy for 7 cycles, done afterwards.
        start0 = 1; len0 = 5;
        step();
        start0 = 0;
        busy_cycles = busy0 ? 1 : 0;
        repeat (8) begin
            step();
            if (busy0) busy_cycles++;
        end
        chk("busy len L5", busy_cycles, 7);
        chk("tog after L5", tog0, 2'b01);

        // Two minimal bursts exercise pointer wrap.
        for (int b = 0; b < 2; b++) begin
            start0 = 1; len0 = 0;
            step();
            start0 = 0;
            repeat (3) step();
        end
        chk("tog after L0 pair", tog0, 2'b10);

        // Abort sampled while cnt==3.
        start0 = 1; len0 = 8;
        step();
        start0 = 0;
        waited = 0;
        while (cnt0 != 4'd3 && waited < 20) begin
            step();
            waited++;
        end
        chk("reach cnt3", cnt0, 4'd3);
        abort0 = 1;
        step();
        abort0 = 0;
        repeat (2) step();
        start0 = 1; abort0 = 1;
        step();
        start0 = 0; abort0 = 0;
        step();

        // Maximal run length saturates; run_len change mid-burst is ignored.
        start0 = 1; len0 = 4'd15;
        step();
        start0 = 0; len0 = 4'd3;
        repeat (18) step();

        // start held high: back-to-back bursts.
        start0 = 1; len0 = 1;
        repeat (12) step();
        start0 = 0;
        repeat (4) step();

        // Asynchronous reset mid-burst at cnt==2.
        start0 = 1; len0 = 6;
        step();
        start0 = 0;
        repeat (2) step();
        chk("pre-reset cnt", cnt0, 4'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 rst_n = 1'b1;
        start0 = 1; len0 = 5;
        step();
        start0 = 0;
        repeat (8) step();

        // Random traffic on both instances.
        repeat (400) begin
            start0 = ($urandom_range(0, 2) != 0);
            abort0 = ($urandom_range(0, 9) == 0);
            len0   = CW'($urandom_range(0, CMAX));
            abort1 = ($urandom_range(0, 11) == 0);
            len1   = CW'($urandom_range(0, CMAX));
            start1 = $urandom_range(0, 1) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
